mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-client arbiter sitting directly upstream of the synchronous read/write memory model. It merges the instruction-fetch read port (IF) and the load/store port (LS) onto the memory's single request/response port. It latches each granted request and holds it stable for the memory's variable-latency handshake. The memory's response is returned to the owning client as a one-cycle pulse.

## Interface
Parameters:
- ADDR_SHIFT, 2, right shift applied to client byte addresses to form the memory word index
- TIMEOUT, 255, busy-cycle count at which the sticky `timeout_flag` is set

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req  in  1  IF read request; level, held until `if_rvalid`
- if_addr  in  32  IF byte address
- if_rdata  out  32  IF read data, valid with `if_rvalid`
- if_rvalid  out  1  one-cycle IF response pulse
- ls_req  in  1  LS request; level, held until response
- ls_we  in  1  1 = write, 0 = read
- ls_addr  in  32  LS byte address
- ls_wdata  in  32  LS write data
- ls_wmask  in  4  LS byte enables; bit n covers bits [8n+7:8n]
- ls_rdata  out  32  LS read data, valid with `ls_rvalid`
- ls_rvalid  out  1  one-cycle LS read response pulse
- ls_wdone  out  1  one-cycle LS write completion pulse
- mem_rreq  out  1  memory read request
- mem_raddr  out  32  memory read word index
- mem_rdata  in  32  memory read data, valid while `mem_data_valid`
- mem_data_valid  in  1  memory read completion
- mem_wreq  out  1  memory write request
- mem_waddr  out  32  memory write word index
- mem_wdata  out  32  memory write data
- mem_wmask  out  4  memory write byte enables
- mem_write_done  in  1  memory write completion
- timeout_flag  out  1  sticky flag: a transaction exceeded TIMEOUT busy cycles

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR, DONE.
- IDLE arbitration:
  - If only one client is requesting, it is granted.
  - If both are requesting, the client not granted last wins (round-robin). `last_grant` resets to LS, so IF wins the first tie.
- On grant, the following are registered into the `addr_q`/`wdata_q`/`wmask_q` registers:
  - address, formed as `{ADDR_SHIFT zeros, addr[31:ADDR_SHIFT]}`; the low ADDR_SHIFT address bits are discarded
  - for LS, also `ls_wdata`, `ls_wmask` and `ls_we`
- Next state after grant: IF grant -> IF_RD; LS grant with `ls_we=0` -> LS_RD; LS grant with `ls_we=1` -> LS_WR.
- IF_RD/LS_RD: `mem_rreq=1`, `mem_raddr=addr_q`. On `mem_data_valid`, capture `mem_rdata` into the response register, then go to DONE.
- LS_WR: `mem_wreq=1`, `mem_waddr=addr_q`, `mem_wdata=wdata_q`, `mem_wmask=wmask_q`. On `mem_write_done`, go to DONE.
- DONE: drive exactly one response pulse for the finished transaction, then go to IDLE. No grant is made in DONE.
  - IF read -> `if_rvalid`; LS read -> `ls_rvalid`; LS write -> `ls_wdone`.
- Memory outputs outside their active states:
  - `mem_rreq`, `mem_wreq`, `mem_wmask` = 0
  - `mem_raddr`/`mem_waddr` hold `addr_q`
- `if_rdata`/`ls_rdata` hold the last captured value between pulses.
- `mem_data_valid` and `mem_write_done` are ignored outside their matching busy state.
- Client input changes after grant do not affect the in-flight transaction.
- Watchdog:
  - A busy counter increments each cycle in IF_RD/LS_RD/LS_WR and clears in IDLE/DONE.
  - When it reaches TIMEOUT, `timeout_flag` is set and stays set until reset. The counter saturates.
  - The transaction is not aborted.

## Timing
- Reset: state IDLE, `last_grant`=LS, busy counter 0. All outputs 0, including `timeout_flag`, `if_rdata` and `ls_rdata`.
- Reset mid-transaction abandons it: no response pulse is produced. Memory and arbiter share the same reset.
- Cycle sequence:
  - Request sampled in IDLE at edge E0.
  - Memory request asserted in cycle E0..E1.
  - Completion seen at edge Ek.
  - Response pulse in cycle Ek..Ek+1 (DONE).
  - IDLE from Ek+1.
- With zero memory delay, request-to-response is 3 cycles.
- The client must drop `req` during its response cycle or present a new request. `req` still high in the first IDLE cycle is treated as a new request.
- The minimum spacing between transactions is one DONE cycle plus one IDLE cycle.
- Response outputs are registered; memory request outputs decode from state only. There is no combinational path from client inputs to memory outputs.

## Test plan
- IF only: `if_addr=0x10`, memory delay 0 -> `mem_raddr=0x4`, `mem_rreq` high for 2 cycles, `if_rvalid` pulse 3 cycles after request with `if_rdata=mem[4]`.
- LS write then read: write `ls_addr=0x20`, `ls_wdata=0xA5A5_1234`, `ls_wmask=4'b0011` over `mem[8]=0xFFFF_FFFF` -> one `ls_wdone` pulse; read back `ls_rdata=0xFFFF_1234`.
- Simultaneous `if_req`/`ls_req` held high for 4 transactions -> grants alternate IF, LS, IF, LS from reset. Exactly one pulse per transaction, none duplicated.
- Client changes `ls_addr`/`ls_wdata` after grant during a 20-cycle memory delay -> `mem_waddr`/`mem_wdata` stay at the latched values throughout.
- Reset asserted during LS_RD -> next cycle all outputs 0, no `ls_rvalid`. A following IF request completes normally.
- TIMEOUT=8, memory delay 20 -> `timeout_flag` rises on the 8th busy cycle and stays high. The transaction still completes with a valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging the IF read port and the LS read/write port onto one
// variable-latency memory port; the granted request is latched for the whole handshake.
module mem_port_arbiter #(
  parameter int ADDR_SHIFT = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wmask,
  output logic [31:0] ls_rdata,
  output logic        ls_rvalid,
  output logic        ls_wdone,
  output logic        mem_rreq,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic        mem_wreq,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_write_done,
  output logic        timeout_flag
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

  state_t         state_q;
  logic           last_ls_q;
  logic [31:0]    addr_q, wdata_q, if_rdata_q, ls_rdata_q;
  logic [3:0]     wmask_q;
  logic [CW-1:0]  busy_q, busy_d;
  logic           timeout_q, if_rvalid_q, ls_rvalid_q, ls_wdone_q;
  logic           pick_if, pick_ls, is_busy;

  always_comb begin
    pick_if = if_req && (!ls_req || last_ls_q);
    pick_ls = ls_req && !pick_if;
    is_busy = (state_q == IF_RD) || (state_q == LS_RD) || (state_q == LS_WR);
    busy_d  = '0;
    if (is_busy) busy_d = (busy_q == TMAX) ? busy_q : busy_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_ls_q   <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      busy_q      <= '0;
      timeout_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_wdone_q  <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      // Flag rises at the edge where the busy count reaches TIMEOUT and is sticky.
      if (is_busy && busy_d == TMAX) timeout_q <= 1'b1;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_wdone_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_if) begin
            addr_q    <= if_addr >> ADDR_SHIFT;
            last_ls_q <= 1'b0;
            state_q   <= IF_RD;
          end else if (pick_ls) begin
            addr_q    <= ls_addr >> ADDR_SHIFT;
            wdata_q   <= ls_wdata;
            wmask_q   <= ls_wmask;
            last_ls_q <= 1'b1;
            state_q   <= ls_we ? LS_WR : LS_RD;
          end
        end
        IF_RD: if (mem_data_valid) begin
          if_rdata_q  <= mem_rdata;
          if_rvalid_q <= 1'b1;
          state_q     <= DONE;
        end
        LS_RD: if (mem_data_valid) begin
          ls_rdata_q  <= mem_rdata;
          ls_rvalid_q <= 1'b1;
          state_q     <= DONE;
        end
        LS_WR: if (mem_write_done) begin
          ls_wdone_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory-side outputs depend on state and latched registers only.
  assign mem_rreq     = (state_q == IF_RD) || (state_q == LS_RD);
  assign mem_wreq     = (state_q == LS_WR);
  assign mem_raddr    = addr_q;
  assign mem_waddr    = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wmask    = (state_q == LS_WR) ? wmask_q : 4'b0000;
  assign if_rdata     = if_rdata_q;
  assign if_rvalid    = if_rvalid_q;
  assign ls_rdata     = ls_rdata_q;
  assign ls_rvalid    = ls_rvalid_q;
  assign ls_wdone     = ls_wdone_q;
  assign timeout_flag = timeout_q;

endmodule
